// File: rtl/cam_tb_pkg.sv
// Shared types and constants for the synthetic camera pixel-stream generator.
package cam_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VBL  = 2'd1,
    ACT  = 2'd2,
    BLK  = 2'd3
  } state_e;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_FLAT  = 2'd3;

  // Default 640x480 timing.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_BLANK  = 160;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_BLANK  = 45;
  localparam int DEF_DATA_W   = 10;

  // Width of the horizontal/vertical position counters.
  localparam int CNT_W = 16;

endpackage

// File: rtl/cam_pattern_pix.sv
// Pixel-value generator: decodes the selected test pattern from position,
// with a divider-free bar counter for the colour-bar pattern.
module cam_pattern_pix
  import cam_tb_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic [DATA_W-1:0] h_lo,
  input  logic              v_bit3,
  input  logic [1:0]        pat,
  input  logic [7:0]        frame_cnt,
  output logic [DATA_W-1:0] pix
);

  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(8);

  logic [CNT_W-1:0] acc_q, acc_d, acc_sum;
  logic [2:0]       bar_q, bar_d;

  // acc tracks (8*h) mod H_ACTIVE; bar carries floor(8*h/H_ACTIVE).
  always_comb begin
    acc_d   = acc_q;
    bar_d   = bar_q;
    acc_sum = acc_q + STEP_C;
    if (!adv) begin
      acc_d = '0;
      bar_d = '0;
    end else if (acc_sum >= H_ACT_C) begin
      acc_d = acc_sum - H_ACT_C;
      bar_d = bar_q + 3'd1;
    end else begin
      acc_d = acc_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      bar_q <= '0;
    end else begin
      acc_q <= acc_d;
      bar_q <= bar_d;
    end
  end

  always_comb begin
    pix = '0;
    case (pat)
      PAT_BARS:  pix = {bar_q, {(DATA_W-3){1'b1}}};
      PAT_RAMP:  pix = h_lo;
      PAT_CHECK: pix = (h_lo[3] ^ v_bit3) ? '1 : '0;
      default:   pix = DATA_W'({frame_cnt, 2'b00});
    endcase
  end

endmodule

// File: rtl/cam_pattern_gen.sv
// Synthetic camera transmitter: frame/line timing FSM, frame counter and
// pattern latch; pixel values come from cam_pattern_pix.
module cam_pattern_gen
  import cam_tb_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BLANK  = DEF_H_BLANK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_BLANK  = DEF_V_BLANK,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iEN,
  input  logic [1:0]        iPATTERN,
  output logic [DATA_W-1:0] oD,
  output logic              oHS,
  output logic              oVS,
  output logic              oFRAME_DONE,
  output logic [7:0]        oFRAME_CNT,
  output logic              oBUSY,
  output logic [1:0]        oDBG_STATE
);

  localparam int L = H_ACTIVE + H_BLANK;
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(L - 1);
  localparam logic [CNT_W-1:0] VA_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VB_LAST = CNT_W'((V_BLANK > 0) ? V_BLANK - 1 : 0);
  localparam state_e FIRST_ST = (V_BLANK == 0) ? ACT : VBL;

  if (H_BLANK < 1) begin : g_chk_hblank
    $error("H_BLANK must be at least 1");
  end
  if (H_ACTIVE < 8) begin : g_chk_hactive
    $error("H_ACTIVE must be at least 8 for the bar pattern");
  end
  if (V_ACTIVE < 1) begin : g_chk_vactive
    $error("V_ACTIVE must be at least 1");
  end
  if (DATA_W < 4 || DATA_W > CNT_W) begin : g_chk_dataw
    $error("DATA_W out of supported range");
  end
  if (L >= (1 << CNT_W) || V_ACTIVE >= (1 << CNT_W) || V_BLANK >= (1 << CNT_W)) begin : g_chk_cnt
    $error("timing exceeds counter width");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [1:0]       pat_q, pat_d;
  logic [7:0]       fc_q, fc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             start;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    pat_d   = pat_q;
    fc_d    = fc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        h_d   = '0;
        v_d   = '0;
        start = iEN;
      end
      // h/v walk L x V_BLANK line-periods of vertical blank.
      VBL: begin
        if (h_q == L_LAST) begin
          h_d = '0;
          if (v_q == VB_LAST) begin
            v_d     = '0;
            state_d = ACT;
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      ACT: begin
        h_d = h_q + 1'b1;
        if (h_q == H_LAST) state_d = BLK;
      end
      BLK: begin
        if (h_q == L_LAST) begin
          h_d = '0;
          if (v_q == VA_LAST) begin
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            v_d     = '0;
            state_d = IDLE;
            start   = iEN;
          end else begin
            v_d     = v_q + 1'b1;
            state_d = ACT;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame start latches the pattern and the count the flat pattern shows.
    if (start) begin
      state_d = FIRST_ST;
      pat_d   = iPATTERN;
      fc_d    = cnt_d;
      h_d     = '0;
      v_d     = '0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= '0;
      fc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pat_q   <= pat_d;
      fc_q    <= fc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  logic [DATA_W-1:0] pix;

  cam_pattern_pix #(
    .H_ACTIVE (H_ACTIVE),
    .DATA_W   (DATA_W)
  ) u_pix (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .adv       (state_q == ACT),
    .h_lo      (h_q[DATA_W-1:0]),
    .v_bit3    (v_q[3]),
    .pat       (pat_q),
    .frame_cnt (fc_q),
    .pix       (pix)
  );

  assign oHS         = (state_q == ACT);
  assign oVS         = (state_q == ACT) || (state_q == BLK);
  assign oD          = oHS ? pix : '0;
  assign oBUSY       = (state_q != IDLE);
  assign oFRAME_DONE = done_q;
  assign oFRAME_CNT  = cnt_q;
  assign oDBG_STATE  = state_q;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen: directed and random steps checked every cycle
// against a frame-offset reference model of the timing and patterns.
`timescale 1ns/1ps
module tb_cam_pattern_gen;
  import cam_tb_pkg::*;

  localparam int HA    = 16;
  localparam int HB    = 4;
  localparam int VA    = 4;
  localparam int VB    = 2;
  localparam int DW    = 10;
  localparam int L     = HA + HB;
  localparam int FRAME = (VA + VB) * L;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    pat = 2'd0;
  logic [DW-1:0] o_d;
  logic          o_hs, o_vs, o_done, o_busy;
  logic [7:0]    o_cnt;
  logic [1:0]    o_state;

  cam_pattern_gen #(
    .H_ACTIVE (HA),
    .H_BLANK  (HB),
    .V_ACTIVE (VA),
    .V_BLANK  (VB),
    .DATA_W   (DW)
  ) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iEN         (en),
    .iPATTERN    (pat),
    .oD          (o_d),
    .oHS         (o_hs),
    .oVS         (o_vs),
    .oFRAME_DONE (o_done),
    .oFRAME_CNT  (o_cnt),
    .oBUSY       (o_busy),
    .oDBG_STATE  (o_state)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen   = 0;

  // Reference model: whether a frame is running and the cycle offset into it.
  bit m_run  = 1'b0;
  int m_n    = 0;
  int m_pat  = 0;
  int m_fc   = 0;
  int m_cnt  = 0;
  bit m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_pix(int p, int x, int line, int fc);
    case (p)
      0:       return ((x * 8) / HA) * 128 + 127;
      1:       return x % 1024;
      2:       return (((x / 8) + (line / 8)) % 2 == 1) ? 1023 : 0;
      default: return (fc * 4) % 1024;
    endcase
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_run  = 1'b0;
      m_n    = 0;
      m_cnt  = 0;
      m_done = 1'b0;
    end else if (m_run) begin
      m_n++;
      m_done = 1'b0;
      if (m_n == FRAME) begin
        m_done = 1'b1;
        m_cnt  = (m_cnt + 1) % 256;
        if (en) begin
          m_n   = 0;
          m_pat = int'(pat);
          m_fc  = m_cnt;
        end else begin
          m_run = 1'b0;
        end
      end
    end else begin
      m_done = 1'b0;
      if (en) begin
        m_run = 1'b1;
        m_n   = 0;
        m_pat = int'(pat);
        m_fc  = m_cnt;
      end
    end
  endtask

  task automatic check_outputs();
    int     m, line, x;
    bit     e_hs, e_vs;
    int     e_d;
    state_e e_st;
    e_hs = 1'b0;
    e_vs = 1'b0;
    e_d  = 0;
    e_st = IDLE;
    if (m_run) begin
      if (m_n < VB * L) begin
        e_st = VBL;
      end else begin
        m    = m_n - VB * L;
        line = m / L;
        x    = m % L;
        e_vs = 1'b1;
        e_hs = (x < HA);
        e_st = e_hs ? ACT : BLK;
        if (e_hs) e_d = exp_pix(m_pat, x, line, m_fc);
      end
    end
    chk("hs",    o_hs,    e_hs);
    chk("vs",    o_vs,    e_vs);
    chk("data",  o_d,     e_d);
    chk("busy",  o_busy,  m_run);
    chk("done",  o_done,  m_done);
    chk("count", o_cnt,   m_cnt);
    chk("state", o_state, e_st);
    if (o_done === 1'b1) done_seen++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
    end
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Three back-to-back ramp frames; iEN drop and pattern change mid frame 3.
    done_seen = 0;
    en  = 1'b1;
    pat = 2'd1;
    step(1);
    step(2 * FRAME + 60);
    en  = 1'b0;
    pat = 2'd2;
    step(FRAME);
    chk("three_frames_cnt", o_cnt, 3);
    chk("three_frames_done", done_seen, 3);
    chk("idle_after_drop", o_busy, 0);

    // Checker frame (pattern 2 latched now), pattern input scrambled mid-frame.
    en = 1'b1;
    step(1);
    en  = 1'b0;
    pat = 2'($urandom_range(0, 3));
    step(FRAME + 5);

    // Colour-bar frame.
    pat = 2'd0;
    en  = 1'b1;
    step(1);
    en = 1'b0;
    step(FRAME + 5);

    // Reset during an active line.
    pat = 2'd1;
    en  = 1'b1;
    step(1);
    en = 1'b0;
    step(VB * L + 5);
    chk("mid_line_hs", o_hs, 1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("rst_cnt", o_cnt, 0);
    chk("rst_done", o_done, 0);
    chk("rst_data", o_d, 0);
    step(5);

    // Random enables, patterns and occasional resets.
    repeat (800) begin
      en    = ($urandom_range(0, 3) == 0);
      pat   = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 299) != 0);
      step(1);
    end
    rst_n = 1'b1;
    en    = 1'b0;
    step(FRAME + 2);

    // Flat pattern after five frames, then run to counter wrap.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    done_seen = 0;
    pat = 2'd3;
    en  = 1'b1;
    step(5 * FRAME + 1);
    chk("five_frames_cnt", o_cnt, 5);
    step(VB * L);
    chk("flat_hs", o_hs, 1);
    chk("flat_px", o_d, 20);
    step(251 * FRAME - 11 - VB * L);
    en = 1'b0;
    step(20);
    chk("wrap_cnt", o_cnt, 0);
    chk("wrap_done", done_seen, 256);
    chk("wrap_idle", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
